// File: rtl/dma_pkg.sv
// dma_pkg: types and defaults shared by the DMA controller and its users.
//   dma_state_e      - controller FSM states
//   DMA_WORD_SIZE    - default memory word width
//   DMA_DATA_SIZE    - default number of device blocks
//   DMA_BLOCK_WORDS  - default words per block / per memory write
package dma_pkg;

  localparam int DMA_WORD_SIZE   = 16;
  localparam int DMA_DATA_SIZE   = 3;
  localparam int DMA_BLOCK_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_controller.sv
// dma_controller: moves up to DATA_SIZE device blocks into memory, one
// BLOCK_WORDS-wide write per block, after winning the bus from the CPU.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   cmd_valid/addr/length - one-cycle CPU command (base word address, words)
//   bg / br               - bus grant in / bus request out
//   offset, dev_data      - device block select and returned block
//   mem_write/addr/data   - memory write strobe, address, block data
//   mem_ack               - memory write-complete pulse
//   busy, dma_end, cmd_err- status, completion pulse, rejected-command pulse
module dma_controller
  import dma_pkg::*;
#(
  parameter int WORD_SIZE   = DMA_WORD_SIZE,
  parameter int DATA_SIZE   = DMA_DATA_SIZE,
  parameter int BLOCK_WORDS = DMA_BLOCK_WORDS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  input  logic [WORD_SIZE-1:0]             cmd_addr,
  input  logic [WORD_SIZE-1:0]             cmd_length,
  input  logic                             bg,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] dev_data,
  input  logic                             mem_ack,
  output logic                             br,
  output logic [1:0]                       offset,
  output logic                             mem_write,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] mem_data,
  output logic                             busy,
  output logic                             dma_end,
  output logic                             cmd_err
);

  localparam int DW = BLOCK_WORDS * WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] BW = WORD_SIZE'(BLOCK_WORDS);

  dma_state_e           state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           nblk_q, nblk_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [DW-1:0]        buf_q, buf_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 len_ok;
  logic [WORD_SIZE-1:0] blk_addr;

  // Accept only whole blocks, at least one, no more than the device holds.
  always_comb begin
    len_ok = (cmd_length != '0) && ((cmd_length % BW) == '0) &&
             ((cmd_length / BW) <= WORD_SIZE'(DATA_SIZE));
  end

  // Address wraps naturally at WORD_SIZE bits.
  always_comb blk_addr = base_q + WORD_SIZE'(BLOCK_WORDS * int'(idx_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      nblk_q    <= '0;
      base_q    <= '0;
      buf_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nblk_q    <= nblk_d;
      base_q    <= base_d;
      buf_q     <= buf_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nblk_d    = nblk_q;
    base_d    = base_q;
    buf_d     = buf_q;
    cmd_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (len_ok) begin
            base_d  = cmd_addr;
            nblk_d  = 2'(cmd_length / BW);
            idx_d   = '0;
            state_d = S_REQ;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_REQ:   if (bg) state_d = S_LOAD;
      // Losing the grant freezes LOAD/WRITE; the buffer only loads with bg.
      S_LOAD: begin
        if (bg) begin
          buf_d   = dev_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bg && mem_ack) begin
          if (idx_q == nblk_q - 2'd1) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    br        = (state_q == S_REQ) || (state_q == S_LOAD) || (state_q == S_WRITE);
    busy      = (state_q != S_IDLE);
    dma_end   = (state_q == S_DONE);
    cmd_err   = cmd_err_q;
    offset    = (state_q == S_LOAD) ? idx_q : 2'b11;
    mem_write = (state_q == S_WRITE) && bg;
    mem_addr  = (state_q == S_WRITE) ? blk_addr : '0;
    mem_data  = (state_q == S_WRITE) ? buf_q : '0;
  end

endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed bench for dma_controller. A table of command
// vectors covers length acceptance; hand-written sequences cover whole
// transfers, grant loss, address wrap, mid-transfer reset and latency.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_length;
  logic        bg;
  logic [63:0] dev_data;
  logic        mem_ack;
  logic        br;
  logic [1:0]  offset;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic        busy;
  logic        dma_end;
  logic        cmd_err;

  int n_pass = 0;
  int n_tot  = 0;

  dma_controller dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .bg(bg), .dev_data(dev_data), .mem_ack(mem_ack),
    .br(br), .offset(offset), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .dma_end(dma_end), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Device model: every word of a real block is nonzero and tagged with
  // block and word number; offset 3 returns an obvious junk pattern.
  function automatic logic [63:0] blk_of(input logic [1:0] k);
    logic [63:0] r;
    if (k == 2'b11) return 64'hDEAD_BEEF_0BAD_F00D;
    for (int j = 0; j < 4; j++) r[j*16 +: 16] = {4'(k) + 4'd1, 8'hC3, 4'(j)};
    return r;
  endfunction

  always_comb dev_data = blk_of(offset);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues a command, then plays CPU/memory: grant after bg_dly cycles of br,
  // mem_ack ack_dly cycles after the first mem_write of a block, optional
  // grant drop of drop_len cycles at the start of write drop_blk (with a
  // stray mem_ack that must be ignored), optional stray command while busy.
  task automatic run_xfer(input logic [15:0] addr, input int nblk, input int bg_dly,
                          input int ack_dly, input int drop_blk, input int drop_len,
                          input bit busy_cmd, output int nwr, output int nend,
                          output int lat);
    int br_cnt, wr_age, drop_left;
    bit in_wr, was_wr, dropped, fin;
    logic [15:0] exp_a;
    nwr = 0; nend = 0; lat = -1;
    br_cnt = 0; wr_age = 0; drop_left = 0; was_wr = 0; dropped = 0; fin = 0;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_length = 16'(nblk * 4);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      in_wr = busy && (mem_data != 64'd0);
      if (busy && offset != 2'b11) chk("load_offset", 64'(offset), 64'(nwr));
      if (!in_wr) chk("addr_idle_zero", 64'(mem_addr), 64'd0);
      if (in_wr && !was_wr) begin
        wr_age = 0;
        if (nwr == drop_blk && !dropped) begin drop_left = drop_len; dropped = 1; end
      end
      if (br) br_cnt++;
      bg        = br && (br_cnt > bg_dly) && (drop_left == 0);
      mem_ack   = in_wr && ((bg && wr_age == ack_dly) || drop_left > 0);
      cmd_valid = busy_cmd && (cyc == 3);
      if (cmd_valid) begin cmd_addr = 16'h1234; cmd_length = 16'd4; end
      #1;
      chk("no_cmd_err", 64'(cmd_err), 64'd0);
      if (drop_left > 0) begin
        chk("write_gap", 64'(mem_write), 64'd0);
        drop_left--;
      end
      if (in_wr && bg) begin
        chk("mem_write", 64'(mem_write), 64'd1);
        exp_a = addr + 16'(4 * nwr);
        chk("mem_addr", 64'(mem_addr), 64'(exp_a));
        chk("mem_data", mem_data, blk_of(2'(nwr)));
        if (mem_ack) nwr++;
        wr_age++;
      end
      if (dma_end) begin
        nend++;
        lat = cyc;
        chk("br_at_done", 64'(br), 64'd0);
      end
      was_wr = in_wr;
      if (lat >= 0 && !busy) begin fin = 1; break; end
      @(negedge clk);
    end
    cmd_valid = 1'b0; bg = 1'b0; mem_ack = 1'b0;
    if (!fin) chk("xfer_timeout", 64'd0, 64'd1);
    chk("idle_br", 64'(br), 64'd0);
  endtask

  typedef struct {
    logic [15:0] len;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[8];
  int   nwr, nend, lat;
  bit   saw_end;

  initial begin
    vecs[0] = '{16'd4,  1'b0, 1'b1};
    vecs[1] = '{16'd8,  1'b0, 1'b1};
    vecs[2] = '{16'd12, 1'b0, 1'b1};
    vecs[3] = '{16'd6,  1'b1, 1'b0};
    vecs[4] = '{16'd0,  1'b1, 1'b0};
    vecs[5] = '{16'd16, 1'b1, 1'b0};
    vecs[6] = '{16'd3,  1'b1, 1'b0};
    vecs[7] = '{16'd13, 1'b1, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_length = '0;
    bg = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_br", 64'(br), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_offset", 64'(offset), 64'd3);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", mem_data, 64'd0);
    chk("rst_dma_end", 64'(dma_end), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    reset = 1'b0;

    // Command acceptance table.
    foreach (vecs[i]) begin
      cmd_valid = 1'b1; cmd_addr = 16'h0040; cmd_length = vecs[i].len;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_err", i), 64'(cmd_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_br", i), 64'(br), 64'(vecs[i].exp_busy));
      @(negedge clk);
      chk($sformatf("v%0d_err_pulse", i), 64'(cmd_err), 64'd0);
      do_reset();
      chk($sformatf("v%0d_rst_busy", i), 64'(busy), 64'd0);
    end

    // Three blocks from 0x01F4, grant after 3 cycles, ack 2 cycles after write.
    run_xfer(16'h01F4, 3, 3, 2, -1, 0, 1'b0, nwr, nend, lat);
    chk("x3_writes", 64'(nwr), 64'd3);
    chk("x3_ends", 64'(nend), 64'd1);

    // Minimum latency 2+3*nblk with immediate grant and next-cycle ack.
    run_xfer(16'h0100, 1, 0, 1, -1, 0, 1'b0, nwr, nend, lat);
    chk("lat_n1", 64'(lat), 64'd5);
    run_xfer(16'h0100, 3, 0, 1, -1, 0, 1'b0, nwr, nend, lat);
    chk("lat_n3", 64'(lat), 64'd11);

    // Grant lost for 5 cycles at the second write.
    run_xfer(16'h0200, 2, 0, 2, 1, 5, 1'b0, nwr, nend, lat);
    chk("drop_writes", 64'(nwr), 64'd2);
    chk("drop_ends", 64'(nend), 64'd1);

    // Address wrap.
    run_xfer(16'hFFFC, 2, 1, 1, -1, 0, 1'b0, nwr, nend, lat);
    chk("wrap_writes", 64'(nwr), 64'd2);

    // Stray command while busy must not disturb the transfer.
    run_xfer(16'h0300, 3, 1, 1, -1, 0, 1'b1, nwr, nend, lat);
    chk("busy_cmd_writes", 64'(nwr), 64'd3);
    chk("busy_cmd_ends", 64'(nend), 64'd1);

    // Reset during LOAD of block 1.
    cmd_valid = 1'b1; cmd_addr = 16'h0400; cmd_length = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0; bg = 1'b1;
    for (int c = 0; c < 50 && offset != 2'd1; c++) begin
      mem_ack = busy && (mem_data != 64'd0);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("reached_load1", 64'(offset), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_br", 64'(br), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_offset", 64'(offset), 64'd3);
    chk("mid_rst_mem_write", 64'(mem_write), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_mem_data", mem_data, 64'd0);
    chk("mid_rst_dma_end", 64'(dma_end), 64'd0);
    saw_end = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dma_end || busy) saw_end = 1'b1;
    end
    chk("mid_rst_quiet", 64'(saw_end), 64'd0);
    bg = 1'b0;
    run_xfer(16'h0500, 1, 0, 1, -1, 0, 1'b0, nwr, nend, lat);
    chk("post_rst_writes", 64'(nwr), 64'd1);
    chk("post_rst_ends", 64'(nend), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
